cart_bank_mapper: RTL and testbench

- FastClk-synchronous successor to the cartridge bank/IO decode logic.
- Replaces the strobe-clocked (posedge nWE) register writes with synchronised strobes, an edge detector and a write FSM, all in one clock domain.
- Bank registers, the external address width and the synchroniser depth are parametrised.
- Sits between the console cartridge bus pins and the PSRAM/bootrom selects and AddrExt outputs. Sibling register blocks (SPI etc.) keep their own decode.

---
 rtl/cart_bank_mapper.sv | 179 +++++++++++++++++
 tb/tb_cart_bank_mapper.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cart_bank_mapper.sv
// Cartridge bank/IO decode in the FastClk domain: synchronised bus strobes feed a write FSM
// and a registered read path. Build option MAPPER_LOCK_EN adds a sticky lock register at E3.
module cart_bank_mapper #(
  parameter int unsigned EXT_WIDTH   = 6,
  parameter int unsigned BANK_WIDTH  = 8,
  parameter logic [7:0]  BANK_RESET  = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 FastClk,
  input  logic                 Reset,
  input  logic                 nSel,
  input  logic                 nOE,
  input  logic                 nWE,
  input  logic                 nIO,
  input  logic [7:0]           AddrLo,
  input  logic [3:0]           AddrHi,
  input  logic [7:0]           WrData,
  output logic [7:0]           RdData,
  output logic                 RdEn,
  output logic [EXT_WIDTH-1:0] AddrExt,
  output logic                 nPSRAMSel,
  output logic                 BootRomSel
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_ACTIVE = 2'd1,
    COMMIT    = 2'd2
  } wr_state_t;

  wr_state_t state, state_next;

  logic [SYNC_STAGES-1:0] sel_sync, oe_sync, we_sync, io_sync;
  logic nsel_s, noe_s, nwe_s, nio_s, nwe_hist;
  logic we_fall, we_rise;

  logic [7:0] reg_addr, wr_addr, wr_data;
  logic [BANK_WIDTH-1:0] linear, ram, rom0, rom1;
  logic self_flash, enable_bootrom, cfg_unlocked;
  logic mapped;
  logic [7:0] rd_val;
  logic any_rom;
  logic unused_addr;

  assign reg_addr    = {AddrHi, AddrLo[3:0]};
  assign unused_addr = ^AddrLo[7:4];

  // Inactive (high) is the safe reset value for every strobe flop.
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      sel_sync <= '1;
      oe_sync  <= '1;
      we_sync  <= '1;
      io_sync  <= '1;
      nwe_hist <= 1'b1;
    end else begin
      sel_sync <= {sel_sync[SYNC_STAGES-2:0], nSel};
      oe_sync  <= {oe_sync[SYNC_STAGES-2:0], nOE};
      we_sync  <= {we_sync[SYNC_STAGES-2:0], nWE};
      io_sync  <= {io_sync[SYNC_STAGES-2:0], nIO};
      nwe_hist <= nwe_s;
    end
  end

  assign nsel_s  = sel_sync[SYNC_STAGES-1];
  assign noe_s   = oe_sync[SYNC_STAGES-1];
  assign nwe_s   = we_sync[SYNC_STAGES-1];
  assign nio_s   = io_sync[SYNC_STAGES-1];
  assign we_fall = nwe_hist & ~nwe_s;
  assign we_rise = ~nwe_hist & nwe_s;

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (we_fall && !nsel_s && !nio_s) state_next = WR_ACTIVE;
      // A strobe ending in the same cycle as the select still commits.
      WR_ACTIVE: if (we_rise)                      state_next = COMMIT;
                 else if (nsel_s || nio_s)         state_next = IDLE;
      COMMIT:                                      state_next = IDLE;
      default:                                     state_next = IDLE;
    endcase
  end

  // Address and data follow the bus throughout the strobe; the last sample wins.
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      wr_addr <= '0;
      wr_data <= '0;
    end else if (state == WR_ACTIVE) begin
      wr_addr <= reg_addr;
      wr_data <= WrData;
    end
  end

`ifdef MAPPER_LOCK_EN
  logic lock;
  assign cfg_unlocked = ~lock;

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset)
      lock <= 1'b0;
    else if (state == COMMIT && wr_addr == 8'hE3 && !lock && wr_data[0])
      lock <= 1'b1;
  end
`else
  assign cfg_unlocked = 1'b1;
`endif

  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      linear         <= BANK_WIDTH'(BANK_RESET);
      ram            <= BANK_WIDTH'(BANK_RESET);
      rom0           <= BANK_WIDTH'(BANK_RESET);
      rom1           <= BANK_WIDTH'(BANK_RESET);
      self_flash     <= 1'b0;
      enable_bootrom <= 1'b1;
    end else if (state == COMMIT) begin
      case (wr_addr)
        8'hC0: linear <= BANK_WIDTH'(wr_data);
        8'hC1: ram    <= BANK_WIDTH'(wr_data);
        8'hC2: rom0   <= BANK_WIDTH'(wr_data);
        8'hC3: rom1   <= BANK_WIDTH'(wr_data);
        8'hCE: if (cfg_unlocked) self_flash     <= wr_data[0];
        8'hE2: if (cfg_unlocked) enable_bootrom <= wr_data[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    mapped = 1'b1;
    rd_val = 8'h00;
    case (reg_addr)
      8'hC0: rd_val = 8'(linear);
      8'hC1: rd_val = 8'(ram);
      8'hC2: rd_val = 8'(rom0);
      8'hC3: rd_val = 8'(rom1);
      8'hCE: rd_val = {7'h0, self_flash};
      8'hE2: rd_val = {7'h0, enable_bootrom};
`ifdef MAPPER_LOCK_EN
      8'hE3: rd_val = {7'h0, lock};
`endif
      default: mapped = 1'b0;
    endcase
  end

  // Registered read: a same-cycle commit is seen one cycle later.
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      RdEn   <= 1'b0;
      RdData <= 8'h00;
    end else begin
      RdEn   <= ~nsel_s & ~noe_s & ~nio_s & mapped;
      RdData <= mapped ? rd_val : 8'h00;
    end
  end

  always_comb begin
    AddrExt = '0;
    case (AddrHi)
      4'h0:    AddrExt = '0;
      4'h1:    AddrExt = ram[EXT_WIDTH-1:0];
      4'h2:    AddrExt = rom0[EXT_WIDTH-1:0];
      4'h3:    AddrExt = rom1[EXT_WIDTH-1:0];
      default: AddrExt = {linear[EXT_WIDTH-5:0], AddrHi};
    endcase
  end

  assign any_rom    = (AddrHi >= 4'd2) | ((AddrHi == 4'd1) & self_flash);
  assign BootRomSel = any_rom & (&AddrExt) & enable_bootrom;
  // Raw pins here: the PSRAM select must not wait for the synchronisers.
  assign nPSRAMSel  = ~(~nSel & nIO & any_rom & ~BootRomSel);

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Directed bench for cart_bank_mapper (default parameters, SYNC_STAGES=2).
module tb_cart_bank_mapper;

  logic       FastClk = 1'b0;
  logic       Reset;
  logic       nSel, nOE, nWE, nIO;
  logic [7:0] AddrLo;
  logic [3:0] AddrHi;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       RdEn;
  logic [5:0] AddrExt;
  logic       nPSRAMSel;
  logic       BootRomSel;

  int checks   = 0;
  int failures = 0;
  int commit_cnt = 0;
  int commit_base;

  cart_bank_mapper dut (
    .FastClk(FastClk), .Reset(Reset),
    .nSel(nSel), .nOE(nOE), .nWE(nWE), .nIO(nIO),
    .AddrLo(AddrLo), .AddrHi(AddrHi), .WrData(WrData),
    .RdData(RdData), .RdEn(RdEn), .AddrExt(AddrExt),
    .nPSRAMSel(nPSRAMSel), .BootRomSel(BootRomSel)
  );

  always #5 FastClk = ~FastClk;

  always @(posedge FastClk)
    if (2'(dut.state) == 2'd2) commit_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge FastClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    nSel = 1'b1; nOE = 1'b1; nWE = 1'b1; nIO = 1'b1;
  endtask

  task automatic set_addr(input logic [7:0] a);
    AddrHi = a[7:4];
    AddrLo = {4'h0, a[3:0]};
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int low_cycles);
    set_addr(a);
    WrData = d;
    nSel = 1'b0; nIO = 1'b0;
    tick(1);
    nWE = 1'b0;
    tick(low_cycles);
    nWE = 1'b1;
    tick(5);
    bus_idle();
    tick(2);
  endtask

  task automatic io_read(input string tag, input logic [7:0] a,
                         input logic exp_en, input logic [7:0] exp_data);
    set_addr(a);
    nSel = 1'b0; nIO = 1'b0; nOE = 1'b0;
    tick(2);
    check({tag, "_rden_early"}, 32'(RdEn), 32'(1'b0));
    tick(1);
    check({tag, "_rden"}, 32'(RdEn), 32'(exp_en));
    check({tag, "_rddata"}, 32'(RdData), 32'(exp_data));
    bus_idle();
    tick(4);
  endtask

  task automatic comb_at(input logic [3:0] hi);
    AddrHi = hi;
    nSel = 1'b0; nIO = 1'b1;
    #1;
  endtask

  initial begin
    bus_idle();
    set_addr(8'h00);
    WrData = 8'h00;
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
    tick(1);

    // Reset state
    check("rst_state", 32'(dut.state), 32'd0);
    check("rst_rden", 32'(RdEn), 32'd0);
    check("rst_rddata", 32'(RdData), 32'd0);
    io_read("rst_c1", 8'hC1, 1'b1, 8'hFF);
    io_read("rst_e2", 8'hE2, 1'b1, 8'h01);
    comb_at(4'h2);
    check("rst_addrext", 32'(AddrExt), 32'h3F);
    check("rst_bootsel", 32'(BootRomSel), 32'd1);
    check("rst_npsram", 32'(nPSRAMSel), 32'd1);
    comb_at(4'h0);
    check("hi0_addrext", 32'(AddrExt), 32'h00);
    bus_idle();
    tick(1);

    // Write then read ROM0
    commit_base = commit_cnt;
    io_write(8'hC2, 8'h05, 6);
    check("c2_commits", 32'(commit_cnt - commit_base), 32'd1);
    check("c2_idle", 32'(dut.state), 32'd0);
    io_read("c2", 8'hC2, 1'b1, 8'h05);
    comb_at(4'h2);
    check("c2_addrext", 32'(AddrExt), 32'h05);
    check("c2_bootsel", 32'(BootRomSel), 32'd0);
    check("c2_npsram", 32'(nPSRAMSel), 32'd0);
    bus_idle();
    tick(1);

    // Linear mode
    io_write(8'hC0, 8'h02, 4);
    comb_at(4'hA);
    check("lin_2a", 32'(AddrExt), 32'h2A);
    bus_idle();
    io_write(8'hC0, 8'h03, 4);
    comb_at(4'hF);
    check("lin_3f", 32'(AddrExt), 32'h3F);
    check("lin_bootsel", 32'(BootRomSel), 32'd1);
    check("lin_npsram_boot", 32'(nPSRAMSel), 32'd1);
    bus_idle();
    io_write(8'hE2, 8'h00, 4);
    comb_at(4'hF);
    check("e2off_bootsel", 32'(BootRomSel), 32'd0);
    check("e2off_npsram", 32'(nPSRAMSel), 32'd0);
    nIO = 1'b0;
    #1;
    check("io_npsram", 32'(nPSRAMSel), 32'd1);
    bus_idle();

    // self_flash makes the RAM window a ROM window
    comb_at(4'h1);
    check("sf0_npsram", 32'(nPSRAMSel), 32'd1);
    bus_idle();
    io_write(8'hCE, 8'h01, 4);
    comb_at(4'h1);
    check("sf1_addrext", 32'(AddrExt), 32'h3F);
    check("sf1_npsram", 32'(nPSRAMSel), 32'd0);
    bus_idle();
    tick(1);
    io_read("ce", 8'hCE, 1'b1, 8'h01);

    // Aborted write: select drops before the strobe ends
    commit_base = commit_cnt;
    set_addr(8'hC1);
    WrData = 8'h33;
    nSel = 1'b0; nIO = 1'b0;
    tick(1);
    nWE = 1'b0;
    tick(5);
    check("abort_active", 32'(dut.state), 32'd1);
    nSel = 1'b1;
    tick(4);
    check("abort_idle", 32'(dut.state), 32'd0);
    nWE = 1'b1;
    tick(4);
    bus_idle();
    tick(2);
    check("abort_commits", 32'(commit_cnt - commit_base), 32'd0);
    io_read("abort_c1", 8'hC1, 1'b1, 8'hFF);

    // Unmapped address
    io_write(8'hD5, 8'h77, 4);
    io_read("d5", 8'hD5, 1'b0, 8'h00);
    io_read("d5_c0", 8'hC0, 1'b1, 8'h03);
    io_read("d5_c1", 8'hC1, 1'b1, 8'hFF);
    io_read("d5_c3", 8'hC3, 1'b1, 8'hFF);

    // Reset in the middle of a write
    set_addr(8'hC1);
    WrData = 8'h10;
    nSel = 1'b0; nIO = 1'b0;
    tick(1);
    nWE = 1'b0;
    tick(5);
    check("rstw_active", 32'(dut.state), 32'd1);
    Reset = 1'b1;
    #2;
    check("rstw_idle", 32'(dut.state), 32'd0);
    Reset = 1'b0;
    bus_idle();
    tick(3);
    io_read("rstw_c1", 8'hC1, 1'b1, 8'hFF);
    io_read("rstw_c0", 8'hC0, 1'b1, 8'hFF);

`ifdef MAPPER_LOCK_EN
    io_write(8'hE3, 8'h01, 4);
    io_write(8'hE2, 8'h00, 4);
    io_read("lock_e2", 8'hE2, 1'b1, 8'h01);
    io_write(8'hC1, 8'h07, 4);
    io_read("lock_c1", 8'hC1, 1'b1, 8'h07);
    io_write(8'hE3, 8'h00, 4);
    io_read("lock_e3", 8'hE3, 1'b1, 8'h01);
`else
    io_write(8'hE3, 8'h01, 4);
    io_read("nolock_e3", 8'hE3, 1'b0, 8'h00);
    io_write(8'hE2, 8'h00, 4);
    io_read("nolock_e2", 8'hE2, 1'b1, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
